// File: rtl/key_event_queue.sv
// key_event_queue: 16-key round-robin arbiter feeding a show-ahead event FIFO with sticky overflow.
// Define KEY_EVENT_TIMESTAMP_EN to store a free-running 16-bit timestamp with every entry.
module key_event_queue #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [15:0]                key_pulse,
  input  logic                       rd_en,
  input  logic                       clr_ovf,
  input  logic                       irq_en,
  output logic                       ev_valid,
  output logic [3:0]                 ev_code,
  output logic [15:0]                ev_time,
  output logic [$clog2(DEPTH):0]     ev_count,
  output logic                       ovf,
  output logic                       irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [15:0]   pending;
  logic [3:0]    ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [3:0]    code_mem [DEPTH];
  logic [3:0]    gnt_idx;
  logic          found;
  logic          pop;
  logic          grant;
  logic [15:0]   gmask;
  logic          merge;
  // Descending scan so the smallest offset from ptr is the last (winning) assignment.
  always_comb begin
    gnt_idx = '0;
    found = 1'b0;
    for (int k = 15; k >= 0; k--) begin
      if (pending[ptr + 4'(k)]) begin
        gnt_idx = ptr + 4'(k);
        found = 1'b1;
      end
    end
  end
  assign pop   = rd_en & ev_valid;
  assign grant = found & ((count < CW'(DEPTH)) | pop);
  assign gmask = grant ? (16'b1 << gnt_idx) : '0;
  assign merge = |(key_pulse & pending & ~gmask);
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pending <= '0;
      ptr     <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
    end else begin
      pending <= (pending & ~gmask) | key_pulse;
      if (grant) begin
        ptr    <= gnt_idx + 4'd1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(grant) - CW'(pop);
      ovf   <= merge | (ovf & ~clr_ovf);
    end
  end
  always_ff @(posedge clk) begin
    if (rstn && grant) code_mem[wr_ptr] <= gnt_idx;
  end
  assign ev_valid = count != '0;
  assign ev_code  = ev_valid ? code_mem[rd_ptr] : 4'd0;
  assign ev_count = count;
  assign irq      = irq_en & ev_valid;
`ifdef KEY_EVENT_TIMESTAMP_EN
  logic [15:0] ts;
  logic [15:0] time_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (!rstn) ts <= '0;
    else ts <= ts + 16'd1;
  end
  always_ff @(posedge clk) begin
    if (rstn && grant) time_mem[wr_ptr] <= ts;
  end
  assign ev_time = ev_valid ? time_mem[rd_ptr] : 16'd0;
`else
  assign ev_time = 16'd0;
`endif
endmodule

// File: tb/tb_key_event_queue.sv
// tb_key_event_queue: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_key_event_queue;
  localparam int DEPTH = 8;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] key_pulse = '0;
  logic        rd_en = 1'b0;
  logic        clr_ovf = 1'b0;
  logic        irq_en = 1'b1;
  logic        ev_valid;
  logic [3:0]  ev_code;
  logic [15:0] ev_time;
  logic [$clog2(DEPTH):0] ev_count;
  logic        ovf;
  logic        irq;
  int tests = 0;
  int fails = 0;
  bit [15:0] m_pend;
  int        m_ptr;
  bit        m_ovf;
  int        m_ts;
  int        mq[$];
  int        mt[$];

  key_event_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .key_pulse(key_pulse), .rd_en(rd_en), .clr_ovf(clr_ovf),
    .irq_en(irq_en), .ev_valid(ev_valid), .ev_code(ev_code), .ev_time(ev_time),
    .ev_count(ev_count), .ovf(ovf), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_code();
    return mq.size() > 0 ? 4'(mq[0]) : 4'd0;
  endfunction

  function automatic logic [15:0] exp_time();
`ifdef KEY_EVENT_TIMESTAMP_EN
    return mt.size() > 0 ? 16'(mt[0]) : 16'd0;
`else
    return 16'd0;
`endif
  endfunction

  // One clock: model advances from the spec rules, then outputs settle 1 time unit after the edge.
  task automatic step();
    int g;
    bit pop;
    bit [15:0] m;
    pop = rd_en && mq.size() > 0;
    g = -1;
    if (mq.size() < DEPTH || pop)
      for (int k = 0; k < 16; k++)
        if (m_pend[(m_ptr + k) % 16]) begin
          g = (m_ptr + k) % 16;
          break;
        end
    @(posedge clk);
    if (!rstn) begin
      m_pend = '0; m_ptr = 0; m_ovf = 0; m_ts = 0;
      mq.delete(); mt.delete();
    end else begin
      m = (g >= 0) ? 16'(1 << g) : 16'd0;
      if ((key_pulse & m_pend & ~m) != 0) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
      if (pop) begin
        void'(mq.pop_front());
        void'(mt.pop_front());
      end
      if (g >= 0) begin
        mq.push_back(g);
        mt.push_back(m_ts);
        m_ptr = (g + 1) % 16;
      end
      m_pend = (m_pend & ~m) | key_pulse;
      m_ts = (m_ts + 1) % 65536;
    end
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; key_pulse = '0; rd_en = 0; clr_ovf = 0;
    step();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    irq_en = 1'b1;
    do_reset();
    step();
    tests++; if (ev_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%0b exp=0", ev_valid); end
    tests++; if (ev_code !== 4'd0) begin fails++; $display("FAIL reset_code got=%0d exp=0", ev_code); end
    tests++; if (ev_time !== 16'd0) begin fails++; $display("FAIL reset_time got=%0d exp=0", ev_time); end
    tests++; if (ev_count !== '0) begin fails++; $display("FAIL reset_count got=%0d exp=0", ev_count); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got=%0b exp=0", ovf); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq got=%0b exp=0", irq); end
  endtask

  task automatic test_single();
    do_reset();
    key_pulse = 16'h0020;
    step();
    key_pulse = '0;
    tests++; if (ev_valid !== 1'b0) begin fails++; $display("FAIL single_n1_valid got=%0b exp=0", ev_valid); end
    step();
    tests++; if (ev_valid !== 1'b1) begin fails++; $display("FAIL single_valid got=%0b exp=1", ev_valid); end
    tests++; if (ev_code !== 4'd5) begin fails++; $display("FAIL single_code got=%0d exp=5", ev_code); end
    tests++; if (ev_count !== 4'd1) begin fails++; $display("FAIL single_count got=%0d exp=1", ev_count); end
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL single_irq got=%0b exp=1", irq); end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    tests++; if (ev_count !== 4'd0) begin fails++; $display("FAIL single_pop_count got=%0d exp=0", ev_count); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL single_pop_irq got=%0b exp=0", irq); end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    tests++; if (ev_count !== 4'd0) begin fails++; $display("FAIL empty_pop_count got=%0d exp=0", ev_count); end
  endtask

  task automatic test_arbitration();
    int exp_a[3] = '{0, 3, 15};
    int exp_b[2] = '{4, 0};
    do_reset();
    key_pulse = 16'h8009;
    step();
    key_pulse = '0;
    repeat (3) step();
    tests++; if (ev_count !== 4'd3) begin fails++; $display("FAIL arb_count got=%0d exp=3", ev_count); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (ev_code !== 4'(exp_a[i])) begin fails++; $display("FAIL arb_order_a[%0d] got=%0d exp=%0d", i, ev_code, exp_a[i]); end
      rd_en = 1'b1; step(); rd_en = 1'b0;
    end
    key_pulse = 16'h0008;
    step();
    key_pulse = '0;
    step();
    rd_en = 1'b1; step(); rd_en = 1'b0;
    key_pulse = 16'h0011;
    step();
    key_pulse = '0;
    repeat (2) step();
    for (int i = 0; i < 2; i++) begin
      tests++; if (ev_code !== 4'(exp_b[i])) begin fails++; $display("FAIL arb_order_b[%0d] got=%0d exp=%0d", i, ev_code, exp_b[i]); end
      rd_en = 1'b1; step(); rd_en = 1'b0;
    end
  endtask

  task automatic test_full_ovf();
    int exp_d[8] = '{1, 2, 3, 4, 5, 6, 7, 9};
    do_reset();
    key_pulse = 16'h00FF;
    step();
    key_pulse = '0;
    repeat (8) step();
    tests++; if (ev_count !== 4'd8) begin fails++; $display("FAIL full_count got=%0d exp=8", ev_count); end
    key_pulse = 16'h0200;
    step();
    key_pulse = '0;
    step();
    tests++; if (ev_count !== 4'd8) begin fails++; $display("FAIL full_hold_count got=%0d exp=8", ev_count); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL full_no_ovf got=%0b exp=0", ovf); end
    key_pulse = 16'h0200;
    step();
    key_pulse = '0;
    tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL merge_ovf got=%0b exp=1", ovf); end
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL clr_ovf got=%0b exp=0", ovf); end
    tests++; if (ev_code !== 4'd0) begin fails++; $display("FAIL full_head got=%0d exp=0", ev_code); end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    tests++; if (ev_count !== 4'd8) begin fails++; $display("FAIL pushpop_count got=%0d exp=8", ev_count); end
    for (int i = 0; i < 8; i++) begin
      tests++; if (ev_code !== 4'(exp_d[i])) begin fails++; $display("FAIL drain[%0d] got=%0d exp=%0d", i, ev_code, exp_d[i]); end
      rd_en = 1'b1; step(); rd_en = 1'b0;
    end
    repeat (3) step();
    tests++; if (ev_count !== 4'd0) begin fails++; $display("FAIL drain_count got=%0d exp=0", ev_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    key_pulse = 16'h003E;
    step();
    key_pulse = '0;
    repeat (2) step();
    key_pulse = 16'h0020;
    step();
    key_pulse = '0;
    tests++; if (ev_count !== 4'd3) begin fails++; $display("FAIL mid_count got=%0d exp=3", ev_count); end
    tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL mid_ovf got=%0b exp=1", ovf); end
    rstn = 1'b0;
    key_pulse = 16'hFFFF;
    step();
    rstn = 1'b1;
    key_pulse = '0;
    tests++; if (ev_count !== 4'd0) begin fails++; $display("FAIL mid_rst_count got=%0d exp=0", ev_count); end
    tests++; if (ev_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid got=%0b exp=0", ev_valid); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL mid_rst_ovf got=%0b exp=0", ovf); end
    repeat (10) step();
    tests++; if (ev_count !== 4'd0) begin fails++; $display("FAIL mid_later_count got=%0d exp=0", ev_count); end
  endtask

  task automatic test_timestamp();
    logic [15:0] t0;
    logic [15:0] t1;
    do_reset();
    key_pulse = 16'h0080;
    step();
    key_pulse = '0;
    repeat (99) step();
    key_pulse = 16'h0100;
    step();
    key_pulse = '0;
    repeat (3) step();
    tests++; if (ev_count !== 4'd2) begin fails++; $display("FAIL ts_count got=%0d exp=2", ev_count); end
    t0 = ev_time;
    rd_en = 1'b1; step(); rd_en = 1'b0;
    t1 = ev_time;
`ifdef KEY_EVENT_TIMESTAMP_EN
    tests++; if (16'(t1 - t0) !== 16'd100) begin fails++; $display("FAIL ts_delta got=%0d exp=100", 16'(t1 - t0)); end
    tests++; if (t1 !== exp_time()) begin fails++; $display("FAIL ts_value got=%0d exp=%0d", t1, exp_time()); end
`else
    tests++; if (t0 !== 16'd0) begin fails++; $display("FAIL ts_zero0 got=%0d exp=0", t0); end
    tests++; if (t1 !== 16'd0) begin fails++; $display("FAIL ts_zero1 got=%0d exp=0", t1); end
`endif
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      key_pulse = 16'($urandom & $urandom & $urandom);
      rd_en     = ($urandom_range(0, 99) < 45);
      clr_ovf   = ($urandom_range(0, 99) < 5);
      irq_en    = ($urandom_range(0, 99) < 70);
      rstn      = ($urandom_range(0, 499) != 0);
      step();
      tests++;
      if (ev_valid !== (mq.size() > 0) || ev_code !== exp_code() || ev_time !== exp_time() ||
          ev_count !== 4'(mq.size()) || ovf !== m_ovf || irq !== (irq_en && mq.size() > 0)) begin
        fails++;
        if (errs < 10)
          $display("FAIL random c=%0d got v=%0b code=%0d time=%0d cnt=%0d ovf=%0b irq=%0b exp v=%0b code=%0d time=%0d cnt=%0d ovf=%0b",
                   c, ev_valid, ev_code, ev_time, ev_count, ovf, irq, mq.size() > 0, exp_code(), exp_time(), mq.size(), m_ovf);
        errs++;
      end
    end
    rstn = 1'b1; key_pulse = '0; rd_en = 0; clr_ovf = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_arbitration();
    test_full_ovf();
    test_reset_mid();
    test_timestamp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
